// File: rtl/ps2_axil_rx_fifo.sv
// ps2_axil_rx_fifo
//   PS/2 device-to-host receiver feeding a scan-code FIFO, with an AXI4-Lite
//   slave register file (DATA, STATUS, CTRL) and a level interrupt.
//   Optional feature macro: PS2_FRAME_TIMEOUT_EN aborts a stalled frame after
//   TIMEOUT_CYC cycles without a falling ps2_clk edge (sets ferr).
// Ports
//   ACLK, ARESET          clock, asynchronous active-high reset
//   ps2_clk, ps2_data     asynchronous PS/2 pins
//   S_AW*/S_W*/S_B*       AXI4-Lite write channels (AW and W accepted together)
//   S_AR*/S_R*            AXI4-Lite read channels
//   irq                   CTRL.irq_en & (~empty | ovf | perr | ferr)
//
// RX state | meaning
//   S_IDLE   | waiting for a start bit (data=0 on falling edge)
//   S_START  | start bit seen, next edge carries data bit 0
//   S_DATA   | shifting data bits 1..7
//   S_PARITY | next edge carries the odd-parity bit
//   S_STOP   | next edge carries the stop bit; byte pushed or dropped
module ps2_axil_rx_fifo #(
  parameter int FIFO_DEPTH  = 16,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000,
  parameter int C_ADDR_W    = 4
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  input  logic [C_ADDR_W-1:0] S_AWADDR,
  input  logic                S_AWVALID,
  output logic                S_AWREADY,
  input  logic [31:0]         S_WDATA,
  input  logic [3:0]          S_WSTRB,
  input  logic                S_WVALID,
  output logic                S_WREADY,
  output logic [1:0]          S_BRESP,
  output logic                S_BVALID,
  input  logic                S_BREADY,
  input  logic [C_ADDR_W-1:0] S_ARADDR,
  input  logic                S_ARVALID,
  output logic                S_ARREADY,
  output logic [31:0]         S_RDATA,
  output logic [1:0]          S_RRESP,
  output logic                S_RVALID,
  input  logic                S_RREADY,
  output logic                irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] FLOAD = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_f, dat_f, clk_f_q;
  logic [FW-1:0] clk_fc, dat_fc;
  logic          fall, rx_fall;
  state_t        state;
  logic [7:0]    sr;
  logic [2:0]    bit_cnt;
  logic          par_ok;
  logic          push_req, perr_set, ferr_set, timeout;
  logic          rx_en, irq_en, ovf, perr, ferr;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full, pop, do_push, ovf_set;
  logic          aw_ready, bvalid, wr_hs, w1c;
  logic          ar_ready, rvalid, rd_hs, rd_pop;
  logic [31:0]   rdata, rd_mux, status_word;
  logic [15:0]   cnt_ext;
  logic          unused_bits;

  // Pins are synchronised, then a level is accepted only after it differs
  // from the current filtered value for FILTER_LEN consecutive cycles.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_f    <= 1'b1;
      dat_f    <= 1'b1;
      clk_f_q  <= 1'b1;
      clk_fc   <= FLOAD;
      dat_fc   <= FLOAD;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      clk_f_q  <= clk_f;
      if (clk_sync[1] == clk_f) clk_fc <= FLOAD;
      else if (clk_fc == '0) begin
        clk_f  <= clk_sync[1];
        clk_fc <= FLOAD;
      end else clk_fc <= clk_fc - FW'(1);
      if (dat_sync[1] == dat_f) dat_fc <= FLOAD;
      else if (dat_fc == '0) begin
        dat_f  <= dat_sync[1];
        dat_fc <= FLOAD;
      end else dat_fc <= dat_fc - FW'(1);
    end
  end

  assign fall     = clk_f_q & ~clk_f;
  assign rx_fall  = fall & rx_en;
  assign push_req = rx_fall & (state == S_STOP) & dat_f & par_ok;
  assign perr_set = rx_fall & (state == S_STOP) & ~par_ok;
  assign ferr_set = (rx_fall & (state == S_STOP) & ~dat_f) | timeout;

`ifdef PS2_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) to_cnt <= TW'(TIMEOUT_CYC - 1);
    else if (fall || state == S_IDLE) to_cnt <= TW'(TIMEOUT_CYC - 1);
    else if (to_cnt != '0) to_cnt <= to_cnt - TW'(1);
  end
  assign timeout = rx_en & (state != S_IDLE) & (to_cnt == '0) & ~fall;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state   <= S_IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      par_ok  <= 1'b0;
    end else if (!rx_en || timeout) begin
      state <= S_IDLE;
    end else if (fall) begin
      case (state)
        S_IDLE:   if (!dat_f) state <= S_START;
        S_START: begin
          sr      <= {dat_f, sr[7:1]};
          bit_cnt <= 3'd1;
          state   <= S_DATA;
        end
        S_DATA: begin
          sr <= {dat_f, sr[7:1]};
          if (bit_cnt == 3'd7) state <= S_PARITY;
          else bit_cnt <= bit_cnt + 3'd1;
        end
        S_PARITY: begin
          par_ok <= ^{sr, dat_f};
          state  <= S_STOP;
        end
        S_STOP:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // A pop in the same cycle frees a slot, so a push onto a full FIFO succeeds.
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign pop     = rvalid & S_RREADY & rd_pop;
  assign do_push = push_req & (~full | pop);
  assign ovf_set = push_req & full & ~pop;

  always_ff @(posedge ACLK) begin
    if (do_push) mem[wr_ptr] <= sr;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign wr_hs = aw_ready & S_AWVALID & S_WVALID;
  assign w1c   = wr_hs & (S_AWADDR[3:2] == 2'd1) & S_WSTRB[0];
  assign rd_hs = ar_ready & S_ARVALID;

  // Sticky flags: a set in the same cycle as a W1C wins.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_ready <= 1'b0;
      bvalid   <= 1'b0;
      rx_en    <= 1'b0;
      irq_en   <= 1'b0;
      ovf      <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      aw_ready <= S_AWVALID & S_WVALID & ~bvalid & ~aw_ready;
      if (wr_hs) bvalid <= 1'b1;
      else if (S_BREADY) bvalid <= 1'b0;
      if (wr_hs && S_AWADDR[3:2] == 2'd2 && S_WSTRB[0]) begin
        rx_en  <= S_WDATA[0];
        irq_en <= S_WDATA[1];
      end
      if (ovf_set) ovf <= 1'b1;
      else if (w1c && S_WDATA[2]) ovf <= 1'b0;
      if (perr_set) perr <= 1'b1;
      else if (w1c && S_WDATA[3]) perr <= 1'b0;
      if (ferr_set) ferr <= 1'b1;
      else if (w1c && S_WDATA[4]) ferr <= 1'b0;
    end
  end

  assign cnt_ext     = 16'(count);
  assign status_word = {16'b0, cnt_ext[7:0], 3'b0, ferr, perr, ovf, full, empty};

  always_comb begin
    rd_mux = '0;
    case (S_ARADDR[3:2])
      2'd0:    rd_mux = empty ? 32'd0 : {24'b0, mem[rd_ptr]};
      2'd1:    rd_mux = status_word;
      2'd2:    rd_mux = {30'b0, irq_en, rx_en};
      default: rd_mux = '0;
    endcase
  end

  // The DATA value is captured at AR time; the head only moves on the R
  // handshake, and only if the FIFO held a byte when the read was accepted.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ar_ready <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rd_pop   <= 1'b0;
    end else begin
      ar_ready <= S_ARVALID & ~rvalid & ~ar_ready;
      if (rd_hs) begin
        rvalid <= 1'b1;
        rdata  <= rd_mux;
        rd_pop <= (S_ARADDR[3:2] == 2'd0) & ~empty;
      end else if (rvalid && S_RREADY) begin
        rvalid <= 1'b0;
        rd_pop <= 1'b0;
      end
    end
  end

  assign S_AWREADY = aw_ready;
  assign S_WREADY  = aw_ready;
  assign S_BVALID  = bvalid;
  assign S_BRESP   = 2'b00;
  assign S_ARREADY = ar_ready;
  assign S_RVALID  = rvalid;
  assign S_RDATA   = rdata;
  assign S_RRESP   = 2'b00;
  assign irq       = irq_en & (~empty | ovf | perr | ferr);

  assign unused_bits = ^{S_AWADDR, S_ARADDR, S_WDATA, S_WSTRB, cnt_ext};
endmodule

// File: tb/tb_ps2_axil_rx_fifo.sv
module tb_ps2_axil_rx_fifo;
  localparam int DEPTH = 16;
  localparam int FLEN  = 8;
  localparam int TOUT  = 2000;
  localparam int HP    = 16;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        ps2_clk, ps2_data;
  logic [3:0]  S_AWADDR, S_ARADDR;
  logic        S_AWVALID, S_WVALID, S_BREADY, S_ARVALID, S_RREADY;
  logic [31:0] S_WDATA;
  logic [3:0]  S_WSTRB;
  logic        S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID, irq;
  logic [1:0]  S_BRESP, S_RRESP;
  logic [31:0] S_RDATA;

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  logic m_ovf, m_perr, m_ferr, m_irq_en;

  ps2_axil_rx_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FLEN), .TIMEOUT_CYC(TOUT), .C_ADDR_W(4)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .irq(irq)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic par_of(input logic [7:0] b);
    return ~^b;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[15:8] = 8'(q.size());
    s[4] = m_ferr;
    s[3] = m_perr;
    s[2] = m_ovf;
    s[1] = (q.size() == DEPTH);
    s[0] = (q.size() == 0);
    return s;
  endfunction

  function automatic logic exp_irq();
    return m_irq_en & ((q.size() != 0) | m_ovf | m_perr | m_ferr);
  endfunction

  // Frame outcome derived from the protocol rules.
  task automatic model_frame(input logic [7:0] b, input logic par, input logic stop);
    logic par_good;
    par_good = ^{b, par};
    if (!stop) m_ferr = 1'b1;
    if (!par_good) m_perr = 1'b1;
    if (stop && par_good) begin
      if (q.size() == DEPTH) m_ovf = 1'b1;
      else q.push_back(b);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      ps2_data = bits[i];
      wait_cyc(HP);
      ps2_clk = 1'b0;
      wait_cyc(HP);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    send_bits({stop, par, b, 1'b0}, 0, 10);
    ps2_data = 1'b1;
    wait_cyc(FLEN + 6);
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d);
    int n;
    S_AWADDR = a; S_WDATA = d; S_WSTRB = 4'hF;
    S_AWVALID = 1'b1; S_WVALID = 1'b1;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!S_AWREADY && n < 100);
    chk("aw_wait", 32'(n < 100), 32'd1);
    @(posedge ACLK); #1;
    S_AWVALID = 1'b0; S_WVALID = 1'b0;
    n = 0;
    while (!S_BVALID && n < 100) begin @(negedge ACLK); n++; end
    chk("bvalid_wait", 32'(n < 100), 32'd1);
    @(posedge ACLK); #1;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    S_ARADDR = a; S_ARVALID = 1'b1;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!S_ARREADY && n < 100);
    chk("ar_wait", 32'(n < 100), 32'd1);
    @(posedge ACLK); #1;
    S_ARVALID = 1'b0;
    n = 0;
    while (!S_RVALID && n < 100) begin @(negedge ACLK); n++; end
    chk("rvalid_wait", 32'(n < 100), 32'd1);
    d = S_RDATA;
    @(posedge ACLK); #1;
  endtask

  task automatic rd_data_chk(input string tag);
    logic [31:0] d, e;
    axi_read(4'h0, d);
    e = (q.size() != 0) ? {24'b0, q.pop_front()} : 32'd0;
    chk(tag, d, e);
  endtask

  task automatic st_chk(input string tag);
    logic [31:0] d;
    axi_read(4'h4, d);
    chk(tag, d, exp_status());
    chk({tag, "_irq"}, 32'(irq), 32'(exp_irq()));
  endtask

  task automatic w1c(input logic [31:0] v);
    axi_write(4'h4, v);
    if (v[2]) m_ovf = 1'b0;
    if (v[3]) m_perr = 1'b0;
    if (v[4]) m_ferr = 1'b0;
  endtask

  initial begin
    logic [31:0] d, e;
    logic [7:0]  b;
    int          kind, n;

    ARESET = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    S_AWADDR = '0; S_ARADDR = '0; S_WDATA = '0; S_WSTRB = '0;
    S_AWVALID = 0; S_WVALID = 0; S_ARVALID = 0; S_BREADY = 1; S_RREADY = 1;
    q.delete(); m_ovf = 0; m_perr = 0; m_ferr = 0; m_irq_en = 0;
    wait_cyc(3);
    chk("rst_awready", 32'(S_AWREADY), 0);
    chk("rst_bvalid", 32'(S_BVALID), 0);
    chk("rst_arready", 32'(S_ARREADY), 0);
    chk("rst_rvalid", 32'(S_RVALID), 0);
    chk("rst_rdata", S_RDATA, 0);
    chk("rst_irq", 32'(irq), 0);
    ARESET = 1'b0;
    wait_cyc(3);
    st_chk("rst_status");
    axi_read(4'h8, d); chk("rst_ctrl", d, 0);

    // T1
    axi_write(4'h8, 32'h3); m_irq_en = 1;
    axi_read(4'h8, d); chk("ctrl_rb", d, 32'h3);
    send_frame(8'h1C, 1'b0, 1'b1); model_frame(8'h1C, 1'b0, 1'b1);
    axi_read(4'h4, d); chk("t1_status", d, 32'h0100);
    chk("t1_irq", 32'(irq), 32'(exp_irq()));
    rd_data_chk("t1_data");
    st_chk("t1_status_after");
    rd_data_chk("t1_empty_read");
    axi_write(4'hC, 32'hFFFF_FFFF);
    axi_read(4'hC, d); chk("reg_c", d, 0);

    // T2
    for (int i = 0; i <= 16; i++) begin
      b = 8'(i);
      send_frame(b, par_of(b), 1'b1); model_frame(b, par_of(b), 1'b1);
    end
    axi_read(4'h4, d); chk("t2_full_status", d, 32'h1006);
    for (int i = 0; i < 16; i++) rd_data_chk("t2_data");
    w1c(32'h4);
    st_chk("t2_ovf_clear");

    // T3
    send_frame(8'h5A, ~par_of(8'h5A), 1'b1); model_frame(8'h5A, ~par_of(8'h5A), 1'b1);
    st_chk("t3_perr");
    send_frame(8'h5A, par_of(8'h5A), 1'b0); model_frame(8'h5A, par_of(8'h5A), 1'b0);
    st_chk("t3_ferr");
    w1c(32'h18);
    st_chk("t3_clear");

    // randomized frames, errors and reads
    for (int it = 0; it < 12; it++) begin
      b = 8'($urandom_range(0, 255));
      kind = int'($urandom_range(0, 5));
      send_frame(b, par_of(b) ^ (kind == 4), kind != 5);
      model_frame(b, par_of(b) ^ (kind == 4), kind != 5);
      if ($urandom_range(0, 1) == 1) rd_data_chk("rnd_data");
      st_chk("rnd_status");
    end
    w1c(32'h1C);
    while (q.size() != 0) rd_data_chk("rnd_drain");

    // rx_en dropped mid-frame discards the partial byte
    send_bits({1'b1, par_of(8'hA5), 8'hA5, 1'b0}, 0, 4);
    axi_write(4'h8, 32'h2);
    axi_write(4'h8, 32'h3);
    ps2_data = 1'b1; wait_cyc(FLEN + 6);
    b = 8'($urandom_range(0, 255));
    send_frame(b, par_of(b), 1'b1); model_frame(b, par_of(b), 1'b1);
    st_chk("rxen_abort_status");
    rd_data_chk("rxen_abort_data");

    // T4: full FIFO, pop coincides with a push
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, par_of(b), 1'b1); model_frame(b, par_of(b), 1'b1);
    end
    st_chk("t4_full");
    b = 8'($urandom_range(0, 255));
    S_RREADY = 1'b0;
    fork
      send_frame(b, par_of(b), 1'b1);
      begin
        S_ARADDR = 4'h0; S_ARVALID = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!S_ARREADY && n < 100);
        @(posedge ACLK); #1;
        S_ARVALID = 1'b0;
        @(negedge ACLK);
        d = S_RDATA;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!dut.push_req && n < 1000);
        S_RREADY = 1'b1;
        @(posedge ACLK); #1;
      end
    join
    chk("t4_sync", 32'(n < 1000), 32'd1);
    e = {24'b0, q.pop_front()};
    q.push_back(b);
    chk("t4_rdata", d, e);
    st_chk("t4_status");
    while (q.size() != 0) rd_data_chk("t4_order");

    // T5: stalled frame
    send_bits({1'b1, par_of(8'h1C), 8'h1C, 1'b0}, 0, 4);
`ifdef PS2_FRAME_TIMEOUT_EN
    wait_cyc(TOUT + 100);
    m_ferr = 1'b1;
    st_chk("t5_timeout");
    ps2_data = 1'b1; wait_cyc(FLEN + 6);
    send_frame(8'h1C, par_of(8'h1C), 1'b1); model_frame(8'h1C, par_of(8'h1C), 1'b1);
`else
    wait_cyc(TOUT + 100);
    st_chk("t5_hold");
    send_bits({1'b1, par_of(8'h1C), 8'h1C, 1'b0}, 5, 10);
    ps2_data = 1'b1; wait_cyc(FLEN + 6);
    model_frame(8'h1C, par_of(8'h1C), 1'b1);
`endif
    st_chk("t5_status");
    rd_data_chk("t5_data");
    w1c(32'h1C);

    // T6: reset mid-frame with a read response pending
    send_frame(8'h33, par_of(8'h33), 1'b1); model_frame(8'h33, par_of(8'h33), 1'b1);
    send_bits({1'b1, par_of(8'h77), 8'h77, 1'b0}, 0, 5);
    S_RREADY = 1'b0;
    S_ARADDR = 4'h4; S_ARVALID = 1'b1;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!S_ARREADY && n < 100);
    @(posedge ACLK); #1;
    S_ARVALID = 1'b0;
    @(negedge ACLK);
    chk("t6_rvalid_pending", 32'(S_RVALID), 1);
    #2 ARESET = 1'b1;
    #1;
    chk("t6_rvalid", 32'(S_RVALID), 0);
    chk("t6_rdata", S_RDATA, 0);
    chk("t6_irq", 32'(irq), 0);
    @(posedge ACLK); #1;
    chk("t6_arready", 32'(S_ARREADY), 0);
    chk("t6_awready", 32'(S_AWREADY), 0);
    chk("t6_bvalid", 32'(S_BVALID), 0);
    @(negedge ACLK);
    ARESET = 1'b0;
    S_RREADY = 1'b1;
    ps2_data = 1'b1;
    q.delete(); m_ovf = 0; m_perr = 0; m_ferr = 0; m_irq_en = 0;
    wait_cyc(FLEN + 6);
    st_chk("t6_status_after");
    axi_write(4'h8, 32'h3); m_irq_en = 1;
    send_frame(8'h29, par_of(8'h29), 1'b1); model_frame(8'h29, par_of(8'h29), 1'b1);
    st_chk("t6_status_rx");
    rd_data_chk("t6_data");
    st_chk("t6_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
